// File: rtl/nic_vc_rx_buffer_pkg.sv
// Shared types and helpers for the NIC receive path.
package nic_pkg;

    localparam int unsigned FLIT_W_DEF = 32;

    typedef enum logic [1:0] {
        EMPTY       = 2'd0,
        VACANT      = 2'd1,
        ALMOST_FULL = 2'd2,
        FULL        = 2'd3
    } vc_state_t;

    typedef logic [FLIT_W_DEF-1:0] flit_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nic_vc_rx_buffer_fifo.sv
// Single-VC circular FIFO with wrap-bit pointers and a registered fill state.
module nic_vc_fifo
    import nic_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [FLIT_WIDTH-1:0] wdata_i,
    output logic [FLIT_WIDTH-1:0] rdata_c,
    output vc_state_t             state
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [CW-1:0]         wr_q, wr_d, rd_q, rd_d, cnt_d;
    vc_state_t             state_q, state_d;
    logic [FLIT_WIDTH-1:0] mem [DEPTH];

    // State is derived from the count the pointers will hold after this edge.
    always_comb begin
        wr_d    = wr_q + CW'(push_i);
        rd_d    = rd_q + CW'(pop_i);
        cnt_d   = wr_d - rd_d;
        state_d = VACANT;
        if (cnt_d == CW'(0)) begin
            state_d = EMPTY;
        end else if (cnt_d == CW'(DEPTH)) begin
            state_d = FULL;
        end else if (cnt_d == CW'(DEPTH - 1)) begin
            state_d = ALMOST_FULL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            state_q <= EMPTY;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            state_q <= state_d;
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem[wr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_c = mem[rd_q[AW-1:0]];
    assign state   = state_q;

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        pop_i |-> (state_q != EMPTY));
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (wr_q - rd_q) <= CW'(DEPTH));

endmodule

// File: rtl/nic_vc_rx_buffer.sv
// Per-VC receive buffer: input demux, round-robin output arbiter with lock, overflow flags.
module nic_vc_rx_buffer
    import nic_pkg::*;
#(
    parameter  int unsigned FLIT_WIDTH = 32,
    parameter  int unsigned NUM_VC     = 4,
    parameter  int unsigned DEPTH      = 16,
    localparam int unsigned VC_W       = clog2_min1(NUM_VC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [VC_W-1:0]       in_vc,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    output logic [NUM_VC-1:0]     in_ready_vc,
    output logic                  out_valid,
    output logic [VC_W-1:0]       out_vc,
    output logic [FLIT_WIDTH-1:0] out_flit,
    input  logic                  out_ready,
    output logic [2*NUM_VC-1:0]   vc_state,
    output logic [NUM_VC-1:0]     overflow_err,
    input  logic                  clr_err
);

    logic [NUM_VC-1:0]     push, pop, drop, nonempty, full;
    logic [NUM_VC-1:0]     err_q, err_d;
    logic                  lock_q, lock_d;
    logic [VC_W-1:0]       lock_vc_q, lock_vc_d, rr_last_q, rr_last_d, grant;
    vc_state_t             st   [NUM_VC];
    logic [FLIT_WIDTH-1:0] head [NUM_VC];

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        nic_vc_fifo #(
            .FLIT_WIDTH (FLIT_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (push[v]),
            .pop_i   (pop[v]),
            .wdata_i (in_flit),
            .rdata_c (head[v]),
            .state   (st[v])
        );
        assign full[v]           = (st[v] == FULL);
        assign nonempty[v]       = (st[v] != EMPTY);
        assign in_ready_vc[v]    = !full[v];
        assign vc_state[2*v +: 2] = st[v];
    end

    // Grant the first non-empty VC after rr_last; a pending lock overrides it.
    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        for (int unsigned i = 1; i <= NUM_VC; i++) begin
            logic [VC_W-1:0] idx;
            idx = VC_W'((32'(rr_last_q) + i) % NUM_VC);
            if (!found && nonempty[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        out_valid = |nonempty;
        out_vc    = lock_q ? lock_vc_q : grant;
        out_flit  = head[out_vc];
    end

    always_comb begin
        push = '0;
        pop  = '0;
        drop = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            push[v] = in_valid && (in_vc == VC_W'(v)) && !full[v];
            drop[v] = in_valid && (in_vc == VC_W'(v)) && full[v];
            pop[v]  = out_valid && out_ready && (out_vc == VC_W'(v));
        end
        err_d     = (clr_err ? '0 : err_q) | drop;
        lock_d    = out_valid && !out_ready;
        lock_vc_d = out_vc;
        rr_last_d = (out_valid && out_ready) ? out_vc : rr_last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= '0;
            lock_q    <= 1'b0;
            lock_vc_q <= '0;
            rr_last_q <= VC_W'(NUM_VC - 1);
        end else begin
            err_q     <= err_d;
            lock_q    <= lock_d;
            lock_vc_q <= lock_vc_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign overflow_err = err_q;

    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && out_vc == $past(out_vc)));

endmodule
